comb4_sweep_ctrl: RTL and testbench

Self-test sequencer for a 4-input combinational function block (inputs a, b, c, d; output y).
On start, it drives all 16 input combinations in order and waits a programmable settle time per vector. It then samples y, builds the observed 16-entry truth table and compares it against an expected table.
It sits between a host/test controller and the function block, and replaces hand-written stimulus sequences.

---
 rtl/comb4_sweep_pkg.sv | 15 +
 rtl/comb4_sweep_ctrl_if.sv | 25 ++
 rtl/comb4_sweep_ctrl_settle_timer.sv | 26 ++
 rtl/comb4_sweep_ctrl.sv | 115 +++++++++++
 tb/tb_comb4_sweep_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/comb4_sweep_pkg.sv
// Shared constants and state encoding for the 4-input truth-table sweep controller.
package comb4_sweep_pkg;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef logic [1:0] sweep_state_t;

  localparam sweep_state_t ST_IDLE   = 2'd0;
  localparam sweep_state_t ST_DRIVE  = 2'd1;
  localparam sweep_state_t ST_SAMPLE = 2'd2;
  localparam sweep_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/comb4_sweep_ctrl_if.sv
// Host-side control and result signals of the sweep controller.
interface comb4_sweep_ctrl_if;
  import comb4_sweep_pkg::*;

  logic             start;
  logic             abort;
  logic [N_VEC-1:0] expected;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_VEC-1:0] truth_table;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [IDX_W-1:0] first_fail_idx;

  modport master (
    output start, abort, expected,
    input  busy, done, pass, truth_table, mismatch_cnt, first_fail_idx
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, pass, truth_table, mismatch_cnt, first_fail_idx
  );

endinterface

// File: rtl/comb4_sweep_ctrl_settle_timer.sv
// Settle-time counter: counts cycles a vector has been held and flags the last one.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign tc = (count == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/comb4_sweep_ctrl.sv
// Self-test sequencer: walks all 16 inputs of a 4-input block, records y and
// compares the observed truth table against the expected one.
module comb4_sweep_ctrl
  import comb4_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  comb4_sweep_ctrl_if.slave  host,
  input  logic               y,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d
);

  sweep_state_t     state, state_next;
  logic [IDX_W-1:0] idx;
  logic [N_VEC-1:0] exp_q;
  logic [N_VEC-1:0] truth_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] ffi_q;
  logic             pass_q;
  logic             settle_tc;
  logic             accept;
  logic             last_vec;
  logic             miss;

  assign accept   = (state == ST_IDLE) && host.start && !host.abort;
  assign last_vec = (idx == IDX_W'(N_VEC - 1));
  assign miss     = (y != exp_q[idx]);

  sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ST_DRIVE),
    .enable (state == ST_DRIVE),
    .tc     (settle_tc)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_DRIVE;
      ST_DRIVE:  if (host.abort) state_next = ST_IDLE;
                 else if (settle_tc) state_next = ST_SAMPLE;
      ST_SAMPLE: if (host.abort) state_next = ST_IDLE;
                 else if (last_vec) state_next = ST_DONE;
                 else state_next = ST_DRIVE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // pass is resolved on entry to DONE so it is already valid alongside the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      exp_q   <= '0;
      truth_q <= '0;
      cnt_q   <= '0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx     <= '0;
            exp_q   <= host.expected;
            truth_q <= '0;
            cnt_q   <= '0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          truth_q[idx] <= y;
          if (miss) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == '0) ffi_q <= idx;
          end
          if (!host.abort) begin
            if (last_vec) pass_q <= (cnt_q == '0) && !miss;
            else idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (host.abort) pass_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    {a, b, c, d} = 4'd0;
    if (state == ST_DRIVE || state == ST_SAMPLE) {a, b, c, d} = idx;
  end

  assign host.busy           = (state != ST_IDLE);
  assign host.done           = (state == ST_DONE);
  assign host.pass           = pass_q;
  assign host.truth_table    = truth_q;
  assign host.mismatch_cnt   = cnt_q;
  assign host.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_comb4_sweep_ctrl.sv
// Scoreboard bench for comb4_sweep_ctrl: default settle time and a SETTLE_CYCLES=1 variant.
module tb_comb4_sweep_ctrl;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  ffi;
    logic        pass;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic y0, y1, stub_zero;
  logic a0, b0, c0, d0, a1, b1, c1, d1;
  int   cyc = 0;
  int   start_cyc0 = 0, start_cyc1 = 0;
  int   n_checks = 0, n_pass = 0;
  exp_t q0[$], q1[$];
  exp_t m0_e, m1_e;

  comb4_sweep_ctrl_if if0 ();
  comb4_sweep_ctrl_if if1 ();

  comb4_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(if0), .y(y0),
    .a(a0), .b(b0), .c(c0), .d(d0)
  );

  comb4_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(if1), .y(y1),
    .a(a1), .b(b1), .c(c1), .d(d1)
  );

  assign y0 = stub_zero ? 1'b0 : ((a0 & b0) | (c0 & d0));
  assign y1 = (a1 & b1) | (c1 & d1);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual === required) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
  endtask

  // Scoreboard monitors: compare every done pulse against the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && if0.done) begin
      if (q0.size() == 0) check_output("dut0_unexpected_done", 32'(if0.done), 32'd0);
      else begin
        m0_e = q0.pop_front();
        check_output("dut0_done_cycle", 32'(cyc - start_cyc0 + 1), 32'(m0_e.done_cyc));
        check_output("dut0_truth_table", 32'(if0.truth_table), 32'(m0_e.tt));
        check_output("dut0_mismatch_cnt", 32'(if0.mismatch_cnt), 32'(m0_e.cnt));
        check_output("dut0_first_fail_idx", 32'(if0.first_fail_idx), 32'(m0_e.ffi));
        check_output("dut0_pass", 32'(if0.pass), 32'(m0_e.pass));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.done) begin
      if (q1.size() == 0) check_output("dut1_unexpected_done", 32'(if1.done), 32'd0);
      else begin
        m1_e = q1.pop_front();
        check_output("dut1_done_cycle", 32'(cyc - start_cyc1 + 1), 32'(m1_e.done_cyc));
        check_output("dut1_truth_table", 32'(if1.truth_table), 32'(m1_e.tt));
        check_output("dut1_mismatch_cnt", 32'(if1.mismatch_cnt), 32'(m1_e.cnt));
        check_output("dut1_first_fail_idx", 32'(if1.first_fail_idx), 32'(m1_e.ffi));
        check_output("dut1_pass", 32'(if1.pass), 32'(m1_e.pass));
      end
    end
  end

  // Issues one start (held for 'hold' edges); returns at the negedge of cycle 'hold'
  task automatic apply_stimulus(input int dut, input logic [15:0] exp_tbl, input logic zero, input int hold);
    @(negedge clk);
    if (dut == 0) begin
      stub_zero = zero;
      if0.expected = exp_tbl;
      if0.start = 1'b1;
    end else begin
      if1.expected = exp_tbl;
      if1.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (dut == 0) start_cyc0 = cyc;
    else start_cyc1 = cyc;
    repeat (hold) @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic wait_drain(input int dut);
    int n = 0;
    while (((dut == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_timeout", 32'((dut == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  function automatic exp_t mk(input logic [15:0] tt, input logic [4:0] cnt, input logic [3:0] ffi,
                              input logic pass, input int dc);
    exp_t e;
    e.tt = tt; e.cnt = cnt; e.ffi = ffi; e.pass = pass; e.done_cyc = dc;
    return e;
  endfunction

  initial begin
    int vec_err;
    stub_zero = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0; if0.expected = 16'h0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.expected = 16'h0;
    repeat (3) @(negedge clk);
    check_output("reset_abcd", 32'({a0, b0, c0, d0}), 32'd0);
    check_output("reset_busy_done_pass", 32'({if0.busy, if0.done, if0.pass}), 32'd0);
    check_output("reset_results", 32'({if0.truth_table, if0.mismatch_cnt, if0.first_fail_idx}), 32'd0);
    rst_n = 1'b1;

    // Correct block: vectors walk 0..15, three cycles each
    q0.push_back(mk(16'hF888, 5'd0, 4'd0, 1'b1, 49));
    apply_stimulus(0, 16'hF888, 1'b0, 1);
    vec_err = 0;
    for (int k = 1; k <= 48; k++) begin
      if (k > 1) @(negedge clk);
      if ({a0, b0, c0, d0} !== 4'((k - 1) / 3) || if0.busy !== 1'b1) vec_err++;
    end
    check_output("vector_order", 32'(vec_err), 32'd0);
    wait_drain(0);
    repeat (5) @(negedge clk);
    check_output("hold_after_done", 32'({if0.truth_table, if0.pass, if0.busy, if0.done}), 32'({16'hF888, 3'b100}));
    check_output("idle_abcd", 32'({a0, b0, c0, d0}), 32'd0);

    // Single mismatch at vector 3
    q0.push_back(mk(16'hF888, 5'd1, 4'd3, 1'b0, 49));
    apply_stimulus(0, 16'hF880, 1'b0, 1);
    check_output("pass_cleared_on_start", 32'(if0.pass), 32'd0);
    wait_drain(0);

    // Stuck-at-0 block: every vector mismatches
    q0.push_back(mk(16'h0000, 5'd16, 4'd0, 1'b0, 49));
    apply_stimulus(0, 16'hFFFF, 1'b1, 1);
    wait_drain(0);
    stub_zero = 1'b0;

    // Abort during vector 3 drive, with an ignored start at cycle 5
    apply_stimulus(0, 16'hF88F, 1'b0, 1);
    repeat (4) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("abort_pre_vec3", 32'({if0.busy, a0, b0, c0, d0}), 32'({1'b1, 4'd3}));
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    check_output("abort_busy_done_pass", 32'({if0.busy, if0.done, if0.pass}), 32'd0);
    check_output("abort_abcd", 32'({a0, b0, c0, d0}), 32'd0);
    check_output("abort_partial_results", 32'({if0.truth_table, if0.mismatch_cnt, if0.first_fail_idx}),
                 32'({16'h0000, 5'd3, 4'd0}));
    repeat (60) @(negedge clk);
    check_output("abort_no_restart", 32'(if0.busy), 32'd0);

    // Asynchronous reset during vector 7
    apply_stimulus(0, 16'hF888, 1'b0, 1);
    repeat (21) @(negedge clk);
    check_output("pre_reset_state", 32'({if0.truth_table, a0, b0, c0, d0}), 32'({16'h0008, 4'd7}));
    rst_n = 1'b0;
    #1;
    check_output("async_reset_outputs", 32'({if0.busy, if0.done, if0.pass, a0, b0, c0, d0}), 32'd0);
    check_output("async_reset_results", 32'({if0.truth_table, if0.mismatch_cnt, if0.first_fail_idx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(mk(16'hF888, 5'd0, 4'd0, 1'b1, 49));
    apply_stimulus(0, 16'hF888, 1'b0, 1);
    wait_drain(0);

    // SETTLE_CYCLES=1: start held three cycles still yields one sweep
    q1.push_back(mk(16'hF888, 5'd0, 4'd0, 1'b1, 33));
    apply_stimulus(1, 16'hF888, 1'b0, 3);
    wait_drain(1);
    repeat (40) @(negedge clk);
    check_output("dut1_single_sweep", 32'(if1.busy), 32'd0);

    // start and abort together in IDLE: nothing starts, results untouched
    @(negedge clk);
    if1.start = 1'b1;
    if1.abort = 1'b1;
    if1.expected = 16'h0000;
    @(negedge clk);
    if1.start = 1'b0;
    if1.abort = 1'b0;
    check_output("start_abort_idle_busy", 32'(if1.busy), 32'd0);
    repeat (5) @(negedge clk);
    check_output("start_abort_idle_results", 32'({if1.busy, if1.truth_table, if1.pass}), 32'({1'b0, 16'hF888, 1'b1}));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
